// File: rtl/avalon_burst_slave_mem.sv
// Avalon-MM slave word memory with burst writes, fixed-latency pipelined burst reads
// and waitrequest backpressure while a read burst is in flight.
module avalon_burst_slave_mem #(
  parameter int NBDATABYTES = 2,
  parameter int NBADDRBITS  = 8,
  parameter int READLATENCY = 2,
  parameter int MAXBURST    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NBADDRBITS-1:0]    address,
  input  logic [NBDATABYTES-1:0]   byteenable,
  input  logic [8*NBDATABYTES-1:0] writedata,
  output logic [8*NBDATABYTES-1:0] readdata,
  input  logic                     read,
  input  logic                     write,
  output logic                     waitrequest,
  output logic                     readdatavalid,
  input  logic [7:0]               burstcount,
  input  logic                     beginbursttransfer
);

  localparam int DW    = 8 * NBDATABYTES;
  localparam int DEPTH = 2 ** NBADDRBITS;
  localparam int CW    = $clog2(READLATENCY + MAXBURST + 1);

  // Handshake: a command or beat transfers on a rising edge where (read|write) is high
  // and waitrequest is low; readdata is meaningful only while readdatavalid is high.
  typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;

  state_t                  state;
  logic [NBADDRBITS-1:0]   base_addr;
  logic [CW-1:0]           len;
  logic [CW-1:0]           cyc;
  logic [CW-1:0]           remaining;
  logic [CW-1:0]           req_len;
  logic [NBADDRBITS-1:0]   rd_addr;
  logic [NBADDRBITS-1:0]   mem_addr;
  logic                    rd_acc;
  logic                    wr_acc_idle;
  logic                    wr_acc_burst;
  logic                    mem_we;
  logic [DW-1:0]           mem [DEPTH];

  always_comb begin
    req_len = CW'(1);
    if (beginbursttransfer && burstcount != 8'd0) begin
      if (32'(burstcount) > MAXBURST) req_len = CW'(MAXBURST);
      else                            req_len = CW'(burstcount);
    end
  end

  // Read has priority over a simultaneous write in IDLE; the write is dropped.
  assign rd_acc       = (state == IDLE) && read && !waitrequest;
  assign wr_acc_idle  = (state == IDLE) && write && !read && !waitrequest;
  assign wr_acc_burst = (state == WBURST) && write && !waitrequest;
  assign mem_we       = wr_acc_idle || wr_acc_burst;
  assign mem_addr     = (state == WBURST) ? base_addr : address;
  assign rd_addr      = base_addr + NBADDRBITS'(cyc - CW'(READLATENCY));

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int j = 0; j < NBDATABYTES; j++) begin
        if (byteenable[j]) mem[mem_addr][8*j +: 8] <= writedata[8*j +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      waitrequest   <= 1'b1;
      readdatavalid <= 1'b0;
      readdata      <= '0;
      base_addr     <= '0;
      len           <= '0;
      cyc           <= '0;
      remaining     <= '0;
    end else begin
      case (state)
        IDLE: begin
          readdatavalid <= 1'b0;
          if (rd_acc) begin
            state       <= RBURST;
            waitrequest <= 1'b1;
            base_addr   <= address;
            len         <= req_len;
            cyc         <= CW'(1);
          end else begin
            waitrequest <= 1'b0;
            if (wr_acc_idle && req_len > CW'(1)) begin
              state     <= WBURST;
              base_addr <= address + NBADDRBITS'(1);
              remaining <= req_len - CW'(1);
            end
          end
        end
        WBURST: begin
          waitrequest <= 1'b0;
          if (wr_acc_burst) begin
            base_addr <= base_addr + NBADDRBITS'(1);
            remaining <= remaining - CW'(1);
            if (remaining == CW'(1)) state <= IDLE;
          end
        end
        RBURST: begin
          // cyc counts edges since acceptance; beats occupy cyc = LATENCY .. LATENCY+len-1
          cyc <= cyc + CW'(1);
          if (cyc == CW'(READLATENCY) + len) begin
            readdatavalid <= 1'b0;
            waitrequest   <= 1'b0;
            state         <= IDLE;
          end else if (cyc >= CW'(READLATENCY)) begin
            readdatavalid <= 1'b1;
            readdata      <= mem[rd_addr];
          end
        end
        default: begin
          state       <= IDLE;
          waitrequest <= 1'b0;
        end
      endcase
    end
  end

endmodule
